cpu_fetch_stage: RTL

// Instruction-fetch (IF) stage of the 5-stage pipelined CPU. It owns the PC, drives
// the instruction-memory address, and loads the IF/ID register (id_ir, id_pc) consumed
// by the decode stage. It follows the CPU run/idle control (enable, start), honours

---
 rtl/cpu_fetch_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cpu_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID register (ir, pc+1, valid). Follows run/idle control,
// hazard stalls, branch redirects, and parks after fetching a HALT.
module cpu_fetch_stage #(
  parameter int              ADDR_W  = 8,
  parameter int              INSTR_W = 16,
  parameter logic [4:0]      HALT_OP = 5'b00001,
  parameter logic [INSTR_W-1:0] NOP_IR = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_branch_flag,
  input  logic [ADDR_W-1:0]  i_branch_addr,
  output logic [ADDR_W-1:0]  o_i_addr,
  input  logic [INSTR_W-1:0] i_i_datain,
  output logic [INSTR_W-1:0] o_id_ir,
  output logic [ADDR_W-1:0]  o_id_pc,
  output logic               o_id_valid,
  output logic               o_halted,
  output logic [15:0]        o_fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]   r_ir, w_ir_nxt;
  logic [ADDR_W-1:0]    r_id_pc, w_id_pc_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [15:0]          r_cnt, w_cnt_nxt;

  logic [ADDR_W-1:0]    w_pc_inc;
  logic [15:0]          w_cnt_inc;
  logic                 w_is_halt;

  // PC increment wraps naturally at 2^ADDR_W; the count saturates.
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_is_halt = (i_i_datain[INSTR_W-1 -: 5] == HALT_OP);

  // Next-state and IF/ID next values; priority enable > branch > stall > fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_id_pc_nxt = r_id_pc;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_ir_nxt    = NOP_IR;
      w_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // branch/stall have no meaning before the CPU is started
          w_ir_nxt    = NOP_IR;
          w_valid_nxt = 1'b0;
          if (i_start) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = '0;
            w_cnt_nxt   = '0;
          end
        end
        S_FETCH, S_HALT: begin
          if (i_branch_flag) begin
            // flush the wrong-path instruction and restart fetching
            w_pc_nxt    = i_branch_addr;
            w_ir_nxt    = NOP_IR;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_FETCH;
          end else if (i_stall) begin
            // everything holds (defaults)
          end else if (r_state == S_FETCH) begin
            w_ir_nxt    = i_i_datain;
            w_id_pc_nxt = w_pc_inc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_cnt_nxt   = w_cnt_inc;
            if (w_is_halt) w_state_nxt = S_HALT;
          end else begin
            // parked: keep feeding bubbles, pc held
            w_ir_nxt    = NOP_IR;
            w_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_ir_nxt    = NOP_IR;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, PC, IF/ID register and fetch counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= NOP_IR;
      r_id_pc <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_id_pc <= w_id_pc_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_i_addr      = r_pc;
  assign o_id_ir       = r_ir;
  assign o_id_pc       = r_id_pc;
  assign o_id_valid    = r_valid;
  assign o_halted      = (r_state == S_HALT);
  assign o_fetch_count = r_cnt;

endmodule
